updown_count_driver: RTL
========================

Name: updown_count_driver

Overview:
- Command-driven initiator for the 8-bit up/down counter interface (en/m/load/data_in in, count out).
- Accepts a target value over a valid/ready handshake and generates en/m/load pulses until the counter's count equals the target, or jumps directly to it with load.
- Sits between control logic and an updown counter instance; reads the counter's count back as count_in.

Parameters:
- WIDTH, 8, counter width; sets the width of target, count_in, ctr_data and the step counter.
- STEP_GAP, 0, extra idle cycles inserted after each en pulse (0..255).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_target  in  WIDTH  target count
- cmd_jump  in  1  1 = reach the target with a single load; 0 = step toward it
- abort  in  1  cancel the active command
- count_in  in  WIDTH  counter's current count
- ctr_en  out  1  to counter en
- ctr_m  out  1  to counter m (0 = up, 1 = down)
- ctr_load  out  1  to counter load
- ctr_data  out  WIDTH  to counter data_in
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on success
- err  out  1  one-cycle pulse on step-limit overflow

Behaviour:
- Reset: single clock, clk; synchronous active-low reset, rst_n.
  - rst_n low at a clk edge: state IDLE, target_q/dir_q/gap_cnt/step_cnt = 0.
  - Outputs after reset: ctr_en = ctr_m = ctr_load = done = err = busy = 0, ctr_data = 0, cmd_ready = 1.
  - Reset mid-command drops the command with no done and no err.
- Output decode: all outputs are decoded from registered state only, so there are no combinational paths from inputs.
  - ctr_en = (STEP)
  - ctr_load = (LOAD)
  - ctr_m = dir_q
  - ctr_data = target_q
  - done = (DONE)
  - err = (ERR)
- States: IDLE, LOAD, CHECK, STEP, WAIT, DONE, ERR.
- IDLE:
  - Accept on cmd_valid && cmd_ready: latch target_q = cmd_target, clear step_cnt.
  - Next state is LOAD if cmd_jump, else CHECK.
- LOAD: ctr_load high for exactly 1 cycle, then DONE.
- CHECK:
  - count_in == target_q -> DONE.
  - Otherwise dir_q = (count_in > target_q), unsigned compare; go to STEP.
  - There is no wrap shortcut: 250 -> 3 steps down 247 times.
- STEP:
  - ctr_en high 1 cycle; step_cnt increments.
  - Next state is WAIT with gap_cnt = STEP_GAP-1 if STEP_GAP > 0, else CHECK.
  - The counter updates on the edge ending STEP, so count_in is valid in the following CHECK.
- WAIT: decrement gap_cnt; at 0 go to CHECK.
- Step limit: if step_cnt reaches 2^WIDTH-1 in CHECK while still unequal (external interference on the counter) -> ERR.
- DONE and ERR: 1 cycle each, then IDLE. A new command can be accepted the cycle after DONE/ERR.
- Cost per step: 2+STEP_GAP cycles. Already-equal command: accept -> CHECK -> DONE, so done is asserted 2 cycles after the accept edge.
- abort:
  - In LOAD/CHECK/STEP/WAIT: next state IDLE, no done.
  - A pulse already being driven in the current cycle (ctr_en/ctr_load) still completes.
  - abort has priority over all other transitions. It is ignored in IDLE, DONE and ERR; a command presented with abort in IDLE is still accepted.
- cmd_target is ignored when not handshaken; target_q is stable for the whole command.

Decomposition:
- Package updown_pkg:
  - state enum (3-bit)
  - COUNT_W = 8 default
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1, matching counter m encoding
- No sub-module needed. The gap timer is inline (8-bit down-counter).
- Bench instantiates updown_counter as the load so count_in closes the loop.

Test Plan:
- count = 5, cmd_target = 8, jump = 0, STEP_GAP = 0 -> three ctr_en pulses with m = 0, on cycles 2/4/6 after accept; done on cycle 8; count = 8.
- count = 200, target = 197, STEP_GAP = 2 -> three pulses with m = 1, spaced 4 cycles apart; done; count = 197.
- count = 0, target = 0xA5, jump = 1 -> ctr_load high 1 cycle with ctr_data = 0xA5; done next cycle; no ctr_en; count = 0xA5.
- count = 10, target = 10 -> no en/load; done 2 cycles after accept; cmd_ready back to 1 the cycle after done.
- count = 0, target = 50; abort asserted during the 3rd STEP -> exactly 3 en pulses; no done; busy low next cycle; count = 3. A new command is accepted immediately after.
- Bench forces count_in to stay at 0 with target 1 -> err pulse after 255 steps. Separately: rst_n low mid-STEP -> all outputs 0 and cmd_ready = 1 after the edge.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter driver and its counter.
package updown_pkg;

   localparam int COUNT_W = 8;

   // Matches the counter's m input: 0 counts up, 1 counts down.
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_STEP  = 3'd3,
      S_WAIT  = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

endpackage

// File: rtl/updown_counter.sv
// Plain 8-bit up/down counter with synchronous load; the load driven by
// updown_count_driver.
module updown_counter
   import updown_pkg::*;
#(
   parameter int WIDTH = COUNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             m,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] count
);

   // Load wins over counting; m selects direction when enabled.
   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= data_in;
      else if (en)
         count <= (m == DIR_DOWN) ? count - 1'b1 : count + 1'b1;
   end

endmodule

// File: rtl/updown_count_driver.sv
// Command-driven initiator for an up/down counter: steps the counter toward
// a target with en/m pulses, or jumps straight to it with a single load.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; cmd_target and
// cmd_jump are sampled only on that edge and ignored otherwise.
module updown_count_driver
   import updown_pkg::*;
#(
   parameter int WIDTH    = COUNT_W,
   parameter int STEP_GAP = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic             cmd_jump,
   input  logic             abort,
   input  logic [WIDTH-1:0] count_in,
   output logic             ctr_en,
   output logic             ctr_m,
   output logic             ctr_load,
   output logic [WIDTH-1:0] ctr_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output state_t           state_dbg
);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] target_q;
   logic             dir_q;
   logic [7:0]       gap_cnt;
   logic [WIDTH-1:0] step_cnt;

   logic             at_target;
   logic             step_limit;

   assign at_target  = (count_in == target_q);
   assign step_limit = (step_cnt == {WIDTH{1'b1}});

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state decode; abort overrides every transition of an active command.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid)
               state_d = cmd_jump ? S_LOAD : S_CHECK;
         end
         S_LOAD: begin
            state_d = abort ? S_IDLE : S_DONE;
         end
         S_CHECK: begin
            if (abort)
               state_d = S_IDLE;
            else if (at_target)
               state_d = S_DONE;
            else if (step_limit)
               state_d = S_ERR;
            else
               state_d = S_STEP;
         end
         S_STEP: begin
            if (abort)
               state_d = S_IDLE;
            else if (STEP_GAP > 0)
               state_d = S_WAIT;
            else
               state_d = S_CHECK;
         end
         S_WAIT: begin
            if (abort)
               state_d = S_IDLE;
            else if (gap_cnt == 8'd0)
               state_d = S_CHECK;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Command datapath: target latch, direction, step count and gap timer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         target_q <= '0;
         dir_q    <= DIR_UP;
         gap_cnt  <= 8'd0;
         step_cnt <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  target_q <= cmd_target;
                  step_cnt <= '0;
               end
            end
            S_CHECK: begin
               if (state_d == S_STEP)
                  dir_q <= (count_in > target_q) ? DIR_DOWN : DIR_UP;
            end
            S_STEP: begin
               step_cnt <= step_cnt + 1'b1;
               gap_cnt  <= 8'(STEP_GAP - 1);
            end
            S_WAIT: begin
               if (gap_cnt != 8'd0)
                  gap_cnt <= gap_cnt - 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Outputs come from registered state only.
   always_comb begin
      ctr_en    = (state_q == S_STEP);
      ctr_load  = (state_q == S_LOAD);
      ctr_m     = dir_q;
      ctr_data  = target_q;
      done      = (state_q == S_DONE);
      err       = (state_q == S_ERR);
      busy      = (state_q != S_IDLE);
      cmd_ready = (state_q == S_IDLE);
      state_dbg = state_q;
   end

endmodule
